// File: rtl/cdc_fifo_src_arb.sv
// Round-robin packet arbiter feeding a CDC FIFO source port.
// Holds a grant for a whole packet or until MAX_BURST beats have been sent.
module cdc_fifo_src_arb #(
    parameter  int N_INP     = 4,
    parameter  int WIDTH     = 32,
    parameter  int MAX_BURST = 4,
    localparam int IdxW      = (N_INP > 1) ? $clog2(N_INP) : 1,
    localparam int CntW      = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_INP*WIDTH-1:0] req_data_i,
    input  logic [N_INP-1:0]       req_valid_i,
    input  logic [N_INP-1:0]       req_last_i,
    output logic [N_INP-1:0]       req_ready_o,
    output logic [WIDTH-1:0]       fifo_data_o,
    output logic [IdxW-1:0]        fifo_idx_o,
    output logic                   fifo_last_o,
    output logic                   fifo_valid_o,
    input  logic                   fifo_ready_i,
    output logic                   busy_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [IdxW-1:0] srch_idx;
    logic            srch_hit;
    logic [IdxW-1:0] win;
    logic [IdxW-1:0] win_nxt;
    logic            win_valid;
    logic            hs;
    logic            rel;

    // First valid requester at or after rr_ptr_q, wrapping around.
    always_comb begin
        int j;
        j        = 0;
        srch_idx = rr_ptr_q;
        srch_hit = 1'b0;
        for (int k = 0; k < N_INP; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_INP) j = j - N_INP;
            if (!srch_hit && req_valid_i[j]) begin
                srch_hit = 1'b1;
                srch_idx = IdxW'(j);
            end
        end
    end

    assign win       = (state_q == LOCKED) ? grant_q : srch_idx;
    assign win_valid = req_valid_i[win];
    assign win_nxt   = (win == IdxW'(N_INP - 1)) ? '0 : win + 1'b1;

    assign fifo_valid_o = win_valid;
    assign fifo_idx_o   = win;
    assign fifo_last_o  = win_valid & req_last_i[win];
    assign fifo_data_o  = win_valid ? req_data_i[win*WIDTH +: WIDTH] : '0;
    assign busy_o       = (state_q == LOCKED);

    always_comb begin
        req_ready_o      = '0;
        req_ready_o[win] = fifo_ready_i;
    end

    assign hs  = win_valid & fifo_ready_i;
    // Burst cap releases without touching the packet's own last flag.
    assign rel = hs & (fifo_last_o |
                       ((cnt_q + CntW'(1)) == CntW'(MAX_BURST)));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (rel) begin
            state_d  = IDLE;
            cnt_d    = '0;
            rr_ptr_d = win_nxt;
        end else if (hs) begin
            state_d = LOCKED;
            grant_d = win;
            cnt_d   = cnt_q + CntW'(1);
        end else if (win_valid && state_q == IDLE) begin
            state_d = LOCKED;
            grant_d = win;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
